// File: rtl/accel_pkg.sv
// ============================================================================
// Module      : accel_pkg
// Description : Shared types, defaults and helpers for the accelerometer
//               filter/scaler stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package accel_pkg;

    localparam int c_def_num_ch   = 2;
    localparam int c_def_in_w     = 12;
    localparam int c_def_out_w    = 9;
    localparam int c_def_avg_log2 = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Zero-g output code; an inverted channel rests one code below mid-scale.
    function automatic int unsigned zero_g_code(input int unsigned out_w, input logic inv);
        return (32'd1 << (out_w - 1)) - (inv ? 32'd1 : 32'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/accel_scale_clip.sv
// ============================================================================
// Module      : accel_scale_clip
// Description : Combinational average/offset/window/clip/invert datapath,
//               shared by all channels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_scale_clip #(
    parameter int IN_W     = 12,
    parameter int OUT_W    = 9,
    parameter int AVG_LOG2 = 2
) (
    input  logic signed [IN_W+AVG_LOG2-1:0] i_acc,
    input  logic                            i_range_sel,
    input  logic                            i_inv,
    output logic        [OUT_W-1:0]         o_result
);

    localparam int c_zg_i = 1 << (OUT_W - 1);
    localparam int c_hi_i = c_zg_i + (1 << OUT_W) - 1;
    localparam logic [OUT_W:0] c_zg = c_zg_i[OUT_W:0];
    localparam logic [OUT_W:0] c_hi = c_hi_i[OUT_W:0];

    logic signed [IN_W-1:0] w_avg;
    logic        [IN_W-1:0] w_off;
    logic        [OUT_W:0]  w_t;
    logic        [OUT_W-1:0] w_win;
    logic        [OUT_W-1:0] w_raw;

    always_comb begin
        w_avg = IN_W'(i_acc >>> AVG_LOG2);
        // Adding half of full scale to a two's-complement value flips its MSB.
        w_off = {~w_avg[IN_W-1], w_avg[IN_W-2:0]};
        w_t   = (OUT_W+1)'(w_off >> (IN_W - OUT_W - 1));
        if (w_t < c_zg) begin
            w_win = '0;
        end else if (w_t >= c_hi) begin
            w_win = '1;
        end else begin
            w_win = OUT_W'(w_t - c_zg);
        end
        w_raw    = i_range_sel ? w_t[OUT_W:1] : w_win;
        o_result = i_inv ? ~w_raw : w_raw;
    end

endmodule

`default_nettype wire

// File: rtl/accel_filter_scaler.sv
// ============================================================================
// Module      : accel_filter_scaler
// Description : N-channel box-car averaging and range scaling of signed
//               accelerometer samples with one time-shared scale datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_filter_scaler
    import accel_pkg::*;
#(
    parameter int                 NUM_CH   = c_def_num_ch,
    parameter int                 IN_W     = c_def_in_w,
    parameter int                 OUT_W    = c_def_out_w,
    parameter int                 AVG_LOG2 = c_def_avg_log2,
    parameter logic [NUM_CH-1:0]  INV_MASK = 2'b10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      data_rdy,
    input  logic [NUM_CH*IN_W-1:0]    accel_in,
    input  logic                      range_sel,
    output logic                      busy,
    output logic                      overrun,
    output logic                      out_valid,
    output logic [NUM_CH*OUT_W-1:0]   accel_out
);

    localparam int c_acc_w = IN_W + AVG_LOG2;
    localparam int c_ch_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [c_ch_w-1:0] c_last_ch = c_ch_w'(NUM_CH - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [c_ch_w-1:0]          r_ch;
    logic [NUM_CH*IN_W-1:0]     r_sample;
    logic                       r_range;
    logic signed [c_acc_w-1:0]  r_acc    [NUM_CH];
    logic [OUT_W-1:0]           r_shadow [NUM_CH];
    logic                       r_overrun;
    logic                       r_out_valid;

    logic                       w_last_ch;
    logic                       w_window_done;
    logic                       w_capture;
    logic                       w_acc_en;
    logic                       w_scale_en;
    logic signed [IN_W-1:0]     w_cur_sample;
    logic signed [c_acc_w-1:0]  w_cur_acc;
    logic [OUT_W-1:0]           w_scaled;

    assign w_last_ch    = (r_ch == c_last_ch);
    assign w_cur_sample = r_sample[r_ch*IN_W +: IN_W];
    assign w_cur_acc    = r_acc[r_ch];

    assign busy      = (r_state != IDLE);
    assign overrun   = r_overrun;
    assign out_valid = r_out_valid;

    // Window is complete when the frame counter is about to wrap to zero.
    generate
        if (AVG_LOG2 == 0) begin : g_no_avg
            assign w_window_done = 1'b1;
        end else begin : g_avg
            logic [AVG_LOG2-1:0] r_frame_cnt;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_frame_cnt <= '0;
                end else if (w_acc_en && w_last_ch) begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
            assign w_window_done = (r_frame_cnt == {AVG_LOG2{1'b1}});
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_acc_en    = 1'b0;
        w_scale_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (data_rdy) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                w_acc_en = 1'b1;
                if (w_last_ch) begin
                    w_state_nxt = w_window_done ? SCALE : IDLE;
                end
            end
            SCALE: begin
                w_scale_en = 1'b1;
                if (w_last_ch) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_ch        <= '0;
            r_sample    <= '0;
            r_range     <= 1'b0;
            r_overrun   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (r_state == DONE);
            if (data_rdy && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (w_capture) begin
                r_sample <= accel_in;
                r_range  <= range_sel;
                r_ch     <= '0;
            end else if (w_acc_en || w_scale_en) begin
                r_ch <= w_last_ch ? '0 : r_ch + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_acc[k]    <= '0;
                r_shadow[k] <= '0;
            end
        end else if (w_acc_en) begin
            r_acc[r_ch] <= w_cur_acc + c_acc_w'(w_cur_sample);
        end else if (w_scale_en) begin
            r_acc[r_ch]    <= '0;
            r_shadow[r_ch] <= w_scaled;
        end
    end

    accel_scale_clip #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_scale_clip (
        .i_acc       (w_cur_acc),
        .i_range_sel (r_range),
        .i_inv       (INV_MASK[r_ch]),
        .o_result    (w_scaled)
    );

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_out
            localparam logic [OUT_W-1:0] c_rst_code = OUT_W'(zero_g_code(OUT_W, INV_MASK[k]));
            logic [OUT_W-1:0] r_out;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_out <= c_rst_code;
                end else if (r_state == DONE) begin
                    r_out <= r_shadow[k];
                end
            end
            assign accel_out[k*OUT_W +: OUT_W] = r_out;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_accel_filter_scaler.sv
// ============================================================================
// Module      : tb_accel_filter_scaler
// Description : Self-checking bench for accel_filter_scaler (AVG_LOG2 = 0 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accel_filter_scaler;

    localparam int PW = 18;
    localparam logic [PW-1:0] c_rst_out = {9'd255, 9'd256};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          dr0, dr2, rs0, rs2;
    logic [23:0]   in0, in2;
    logic          busy0, busy2, ovr0, ovr2, ov0, ov2;
    logic [PW-1:0] out0, out2;

    accel_filter_scaler #(.NUM_CH(2), .IN_W(12), .OUT_W(9), .AVG_LOG2(0), .INV_MASK(2'b10)) dut0 (
        .clk(clk), .reset(reset), .data_rdy(dr0), .accel_in(in0), .range_sel(rs0),
        .busy(busy0), .overrun(ovr0), .out_valid(ov0), .accel_out(out0));

    accel_filter_scaler #(.NUM_CH(2), .IN_W(12), .OUT_W(9), .AVG_LOG2(2), .INV_MASK(2'b10)) dut2 (
        .clk(clk), .reset(reset), .data_rdy(dr2), .accel_in(in2), .range_sel(rs2),
        .busy(busy2), .overrun(ovr2), .out_valid(ov2), .accel_out(out2));

    typedef struct {
        int   x;
        int   y;
        logic rng;
        int   ex;
        int   ey;
    } vec_t;

    vec_t          vecs[$];
    logic [PW-1:0] q0[$];
    logic [PW-1:0] q2[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int x, input int y, input logic rng, input int ex, input int ey);
        vec_t v;
        v.x = x; v.y = y; v.rng = rng; v.ex = ex; v.ey = ey;
        return v;
    endfunction

    function automatic logic [PW-1:0] pk(input int ex, input int ey);
        return {9'(ey), 9'(ex)};
    endfunction

    function automatic logic get_ov(input int d);
        return (d == 0) ? ov0 : ov2;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? busy0 : busy2;
    endfunction

    task automatic set_in(input int d, input logic dr, input int x, input int y, input logic rng);
        logic [23:0] v;
        v = {12'(y), 12'(x)};
        if (d == 0) begin dr0 = dr; in0 = v; rs0 = rng; end
        else        begin dr2 = dr; in2 = v; rs2 = rng; end
    endtask

    task automatic clr_dr(input int d);
        if (d == 0) dr0 = 1'b0; else dr2 = 1'b0;
    endtask

    // Leaves the caller #1 after the accepting edge E0.
    task automatic drive(input int d, input int x, input int y, input logic rng);
        @(negedge clk);
        set_in(d, 1'b1, x, y, rng);
        @(posedge clk);
        #1;
        clr_dr(d);
    endtask

    task automatic wait_ov(input int d, input int exp_lat, input string name);
        int   lat = 0;
        logic v   = 1'b0;
        while (!v && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            v = get_ov(d);
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " busy in out_valid cycle"}, 32'(get_busy(d)), 32'd0);
    endtask

    task automatic pulse_end(input int d, input string name);
        @(posedge clk);
        #1;
        check({name, " out_valid single cycle"}, 32'(get_ov(d)), 32'd0);
    endtask

    task automatic frame_nf(input int x, input int y, input logic rng, input string name);
        drive(2, x, y, rng);
        check({name, " busy c1"}, 32'(busy2), 32'd1);
        @(posedge clk); #1;
        check({name, " busy c2"}, 32'(busy2), 32'd1);
        @(posedge clk); #1;
        check({name, " busy released"}, 32'(busy2), 32'd0);
        check({name, " no out_valid"}, 32'(ov2), 32'd0);
    endtask

    always @(negedge clk) begin
        if (ov0) begin
            if (q0.size() == 0) check("d0 spurious out_valid", 32'(ov0), 32'd0);
            else                check("d0 accel_out", 32'(out0), 32'(q0.pop_front()));
        end
        if (ov2) begin
            if (q2.size() == 0) check("d2 spurious out_valid", 32'(ov2), 32'd0);
            else                check("d2 accel_out", 32'(out2), 32'(q2.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        dr0 = 1'b0; dr2 = 1'b0; rs0 = 1'b0; rs2 = 1'b0; in0 = '0; in2 = '0;

        vecs.push_back(mk(    0,     0, 1'b0, 256, 255));
        vecs.push_back(mk(-1024,     0, 1'b0,   0, 255));
        vecs.push_back(mk( 1023,     0, 1'b0, 511, 255));
        vecs.push_back(mk( 2047,     0, 1'b0, 511, 255));
        vecs.push_back(mk(-2048,     0, 1'b0,   0, 255));
        vecs.push_back(mk(-1025, -1024, 1'b0,   0, 511));
        vecs.push_back(mk(-1020,  1023, 1'b0,   1,   0));
        vecs.push_back(mk( 1019,  1020, 1'b0, 510,   0));
        vecs.push_back(mk(  500,     0, 1'b0, 381, 255));
        vecs.push_back(mk(    0,     0, 1'b1, 256, 255));
        vecs.push_back(mk( 2047,     0, 1'b1, 511, 255));
        vecs.push_back(mk(-2048,  2047, 1'b1,   0,   0));
        vecs.push_back(mk(-1024, -2048, 1'b1, 128, 511));
        vecs.push_back(mk(  500,    -1, 1'b1, 318, 256));

        repeat (3) @(posedge clk);
        #1;
        check("reset d0 accel_out", 32'(out0), 32'(c_rst_out));
        check("reset d2 accel_out", 32'(out2), 32'(c_rst_out));
        check("reset d0 busy",      32'(busy0), 32'd0);
        check("reset d0 out_valid", 32'(ov0), 32'd0);
        check("reset d0 overrun",   32'(ovr0), 32'd0);
        check("reset d2 busy",      32'(busy2), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            q0.push_back(pk(vecs[i].ex, vecs[i].ey));
            drive(0, vecs[i].x, vecs[i].y, vecs[i].rng);
            wait_ov(0, 5, "d0 table");
            pulse_end(0, "d0 table");
        end

        // New frame accepted in the out_valid cycle
        q0.push_back(pk(268, 268));
        drive(0, 100, -100, 1'b1);
        wait_ov(0, 5, "d0 frame A");
        set_in(0, 1'b1, -100, 100, 1'b0);
        q0.push_back(pk(231, 230));
        @(posedge clk);
        #1;
        clr_dr(0);
        check("d0 accept in out_valid cycle", 32'(busy0), 32'd1);
        wait_ov(0, 5, "d0 frame B");
        pulse_end(0, "d0 frame B");
        check("d0 no overrun after B", 32'(ovr0), 32'd0);

        // data_rdy held for two cycles: second frame dropped
        @(negedge clk);
        set_in(0, 1'b1, 1500, -1500, 1'b1);
        q0.push_back(pk(443, 443));
        @(posedge clk);
        #1;
        set_in(0, 1'b1, 7, 7, 1'b0);
        @(posedge clk);
        #1;
        clr_dr(0);
        check("d0 overrun set", 32'(ovr0), 32'd1);
        wait_ov(0, 4, "d0 overrun frame");
        pulse_end(0, "d0 overrun frame");
        q0.push_back(pk(81, 80));
        drive(0, -700, 700, 1'b0);
        wait_ov(0, 5, "d0 after overrun");
        pulse_end(0, "d0 after overrun");
        check("d0 overrun sticky", 32'(ovr0), 32'd1);

        // Averaging windows; range comes from the last frame
        frame_nf(100, 0, 1'b0, "d2 w1f1");
        frame_nf(200, 0, 1'b0, "d2 w1f2");
        frame_nf(300, 0, 1'b0, "d2 w1f3");
        q2.push_back(pk(287, 255));
        drive(2, 400, 0, 1'b1);
        wait_ov(2, 5, "d2 w1");
        pulse_end(2, "d2 w1");

        frame_nf(-1, 1000, 1'b1, "d2 w2f1");
        frame_nf(-1, 1000, 1'b1, "d2 w2f2");
        frame_nf(-1, 1000, 1'b1, "d2 w2f3");
        q2.push_back(pk(255, 130));
        drive(2, -2, 1001, 1'b1);
        wait_ov(2, 5, "d2 w2");
        pulse_end(2, "d2 w2");

        frame_nf(0, 400, 1'b1, "d2 w3f1");
        frame_nf(0, 400, 1'b1, "d2 w3f2");
        frame_nf(0, 400, 1'b1, "d2 w3f3");
        q2.push_back(pk(255, 155));
        drive(2, -4, 400, 1'b0);
        wait_ov(2, 5, "d2 w3");
        pulse_end(2, "d2 w3");

        // Partial window left in dut2, dut0 interrupted mid-SCALE
        frame_nf(2000, 2000, 1'b1, "d2 partial1");
        frame_nf(2000, 2000, 1'b1, "d2 partial2");
        drive(0, 700, -300, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midreset d0 accel_out", 32'(out0), 32'(c_rst_out));
        check("midreset d2 accel_out", 32'(out2), 32'(c_rst_out));
        check("midreset d0 out_valid", 32'(ov0), 32'd0);
        check("midreset d0 busy",      32'(busy0), 32'd0);
        check("midreset d0 overrun",   32'(ovr0), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post reset d0 idle", 32'(busy0), 32'd0);

        q0.push_back(pk(293, 318));
        drive(0, 300, -500, 1'b1);
        wait_ov(0, 5, "d0 post reset");
        pulse_end(0, "d0 post reset");

        frame_nf(8, 0, 1'b1, "d2 w4f1");
        frame_nf(8, 0, 1'b1, "d2 w4f2");
        frame_nf(8, 0, 1'b1, "d2 w4f3");
        q2.push_back(pk(257, 255));
        drive(2, 8, 0, 1'b1);
        wait_ov(2, 5, "d2 w4");
        pulse_end(2, "d2 w4");

        repeat (4) @(posedge clk);
        #1;
        check("d0 scoreboard drained", 32'(q0.size()), 32'd0);
        check("d2 scoreboard drained", 32'(q2.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
